// File: rtl/alu_pc_dmem.sv
`default_nettype none
// ============================================================================
// Module   : alu_pc_dmem
// Brief    : Program counter, combinational ALU and word-addressed data memory
// Revision : 1.0 - initial release
// ============================================================================
module alu_pc_dmem #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  input  logic [4:0]  alu_fn,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_out,
  input  logic        write_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  localparam int c_idx_w = $clog2(MEM_WORDS);

  localparam logic [4:0] c_fn_none  = 5'd0;
  localparam logic [4:0] c_fn_add   = 5'd1;
  localparam logic [4:0] c_fn_sub   = 5'd2;
  localparam logic [4:0] c_fn_and   = 5'd3;
  localparam logic [4:0] c_fn_or    = 5'd4;
  localparam logic [4:0] c_fn_xor   = 5'd5;
  localparam logic [4:0] c_fn_sll   = 5'd6;
  localparam logic [4:0] c_fn_srl   = 5'd7;
  localparam logic [4:0] c_fn_sra   = 5'd8;
  localparam logic [4:0] c_fn_slt   = 5'd9;
  localparam logic [4:0] c_fn_sltu  = 5'd10;
  localparam logic [4:0] c_fn_beq   = 5'd11;
  localparam logic [4:0] c_fn_bne   = 5'd12;
  localparam logic [4:0] c_fn_blt   = 5'd13;
  localparam logic [4:0] c_fn_bge   = 5'd14;
  localparam logic [4:0] c_fn_bltu  = 5'd15;
  localparam logic [4:0] c_fn_bgeu  = 5'd16;
  localparam logic [4:0] c_fn_jalr  = 5'd17;
  localparam logic [4:0] c_fn_copy1 = 5'd18;

  logic [31:0]        r_pc;
  logic [31:0]        w_alu;
  logic [31:0]        w_sum;
  logic [4:0]         w_shamt;
  logic               w_lt_s;
  logic               w_lt_u;
  logic               w_eq;
  logic [c_idx_w-1:0] w_idx;
  logic [31:0]        r_mem [MEM_WORDS];

  // rst wins over jump; increment wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (jump_flag) begin
      r_pc <= jump_target;
    end else begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign pc = r_pc;

  assign w_sum   = rs1_data + rs2_data;
  assign w_shamt = rs2_data[4:0];
  assign w_lt_s  = $signed(rs1_data) < $signed(rs2_data);
  assign w_lt_u  = rs1_data < rs2_data;
  assign w_eq    = rs1_data == rs2_data;

  always_comb begin
    w_alu = 32'd0;
    case (alu_fn)
      c_fn_none:  w_alu = 32'd0;
      c_fn_add:   w_alu = w_sum;
      c_fn_sub:   w_alu = rs1_data - rs2_data;
      c_fn_and:   w_alu = rs1_data & rs2_data;
      c_fn_or:    w_alu = rs1_data | rs2_data;
      c_fn_xor:   w_alu = rs1_data ^ rs2_data;
      c_fn_sll:   w_alu = rs1_data << w_shamt;
      c_fn_srl:   w_alu = rs1_data >> w_shamt;
      c_fn_sra:   w_alu = $unsigned($signed(rs1_data) >>> w_shamt);
      c_fn_slt:   w_alu = {31'd0, w_lt_s};
      c_fn_sltu:  w_alu = {31'd0, w_lt_u};
      c_fn_beq:   w_alu = {31'd0, w_eq};
      c_fn_bne:   w_alu = {31'd0, ~w_eq};
      c_fn_blt:   w_alu = {31'd0, w_lt_s};
      c_fn_bge:   w_alu = {31'd0, ~w_lt_s};
      c_fn_bltu:  w_alu = {31'd0, w_lt_u};
      c_fn_bgeu:  w_alu = {31'd0, ~w_lt_u};
      c_fn_jalr:  w_alu = w_sum & ~32'h1;
      c_fn_copy1: w_alu = rs1_data;
      default:    w_alu = 32'd0;
    endcase
  end

  assign alu_out = w_alu;

  // Byte-offset and out-of-range address bits are deliberately dropped
  assign w_idx = addr[c_idx_w+1:2];

  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, addr[31:c_idx_w+2], addr[1:0]};

  // Writes are independent of rst so memory survives and keeps updating in reset
  always_ff @(posedge clk) begin
    if (write_en) begin
      r_mem[w_idx] <= write_data;
    end
  end

  assign read_data = r_mem[w_idx];

endmodule
`default_nettype wire

// File: tb/tb_alu_pc_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pc_dmem
// Brief    : Directed scoreboard bench for alu_pc_dmem (PC, ALU, memory)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pc_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [4:0]  alu_fn;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_out;
  logic        write_en;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  alu_pc_dmem #(
    .MEM_WORDS (1024),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .pc          (pc),
    .alu_fn      (alu_fn),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_out     (alu_out),
    .write_en    (write_en),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pc_step(input string tag, input logic r, input logic j,
                         input logic [31:0] tgt, input logic [31:0] exp_pc);
    rst = r;
    jump_flag = j;
    jump_target = tgt;
    push(tag, exp_pc);
    tick();
    check(pc);
  endtask

  task automatic alu_chk(input string tag, input logic [4:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_v);
    alu_fn = fn;
    rs1_data = a;
    rs2_data = b;
    push(tag, exp_v);
    #1;
    check(alu_out);
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    write_en = 1'b1;
    addr = a;
    write_data = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic mem_read(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_v);
    addr = a;
    push(tag, exp_v);
    #1;
    check(read_data);
  endtask

  initial begin
    rst = 1'b1;
    jump_flag = 1'b0;
    jump_target = 32'd0;
    alu_fn = 5'd0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    write_en = 1'b0;
    addr = 32'd0;
    write_data = 32'd0;

    // PC sequencing out of reset
    pc_step("pc_rst0", 1'b1, 1'b0, 32'd0, 32'd0);
    pc_step("pc_rst1", 1'b1, 1'b0, 32'd0, 32'd0);
    pc_step("pc_seq4", 1'b0, 1'b0, 32'd0, 32'd4);
    pc_step("pc_seq8", 1'b0, 1'b0, 32'd0, 32'd8);
    pc_step("pc_seq12", 1'b0, 1'b0, 32'd0, 32'd12);

    // Jump from pc=8, then reset beating a jump, then resume
    pc_step("pc_rst_again", 1'b1, 1'b0, 32'd0, 32'd0);
    pc_step("pc_re4", 1'b0, 1'b0, 32'd0, 32'd4);
    pc_step("pc_re8", 1'b0, 1'b0, 32'd0, 32'd8);
    pc_step("pc_jump100", 1'b0, 1'b1, 32'h100, 32'h100);
    pc_step("pc_104", 1'b0, 1'b0, 32'd0, 32'h104);
    pc_step("pc_rst_over_jump", 1'b1, 1'b1, 32'h200, 32'd0);
    pc_step("pc_resume4", 1'b0, 1'b0, 32'd0, 32'd4);
    pc_step("pc_jump_unaligned", 1'b0, 1'b1, 32'h103, 32'h103);
    pc_step("pc_jump_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    pc_step("pc_wrap", 1'b0, 1'b0, 32'd0, 32'd0);

    // ALU arithmetic / logic / shifts
    alu_chk("alu_add_wrap", 5'd1, 32'hFFFF_FFF0, 32'h10, 32'h0);
    alu_chk("alu_sub", 5'd2, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFE0);
    alu_chk("alu_and", 5'd3, 32'hFFFF_FFF0, 32'h10, 32'h10);
    alu_chk("alu_or", 5'd4, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFF0);
    alu_chk("alu_xor", 5'd5, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFE0);
    alu_chk("alu_slt", 5'd9, 32'hFFFF_FFF0, 32'h10, 32'd1);
    alu_chk("alu_sltu", 5'd10, 32'hFFFF_FFF0, 32'h10, 32'd0);
    alu_chk("alu_sra", 5'd8, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF);
    alu_chk("alu_srl", 5'd7, 32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF);
    alu_chk("alu_sll_upper_ignored", 5'd6, 32'd1, 32'h24, 32'h10);
    alu_chk("alu_blt", 5'd13, 32'hFFFF_FFF0, 32'h10, 32'd1);
    alu_chk("alu_bgeu", 5'd16, 32'hFFFF_FFF0, 32'h10, 32'd1);
    alu_chk("alu_beq", 5'd11, 32'd5, 32'd5, 32'd1);
    alu_chk("alu_bne", 5'd12, 32'd5, 32'd5, 32'd0);
    alu_chk("alu_bge", 5'd14, 32'd5, 32'd5, 32'd1);
    alu_chk("alu_bltu", 5'd15, 32'd5, 32'd5, 32'd0);
    alu_chk("alu_jalr", 5'd17, 32'h1001, 32'd0, 32'h1000);
    alu_chk("alu_jalr_wrap", 5'd17, 32'hFFFF_FFFF, 32'd2, 32'd0);
    alu_chk("alu_copy1", 5'd18, 32'hCAFE_F00D, 32'd7, 32'hCAFE_F00D);
    alu_chk("alu_none", 5'd0, 32'hCAFE_F00D, 32'd7, 32'd0);
    alu_chk("alu_fn19", 5'd19, 32'd5, 32'd5, 32'd0);
    alu_chk("alu_fn25", 5'd25, 32'd5, 32'd5, 32'd0);
    alu_chk("alu_fn31", 5'd31, 32'd5, 32'd5, 32'd0);

    // Memory: aliasing, write enable, same-cycle read/write
    mem_write(32'h10, 32'hDEAD_BEEF);
    mem_read("mem_rd_10", 32'h10, 32'hDEAD_BEEF);
    mem_read("mem_rd_13", 32'h13, 32'hDEAD_BEEF);
    mem_read("mem_rd_1010", 32'h1010, 32'hDEAD_BEEF);
    write_en = 1'b0;
    write_data = 32'h1234_5678;
    addr = 32'h10;
    tick();
    mem_read("mem_no_we", 32'h10, 32'hDEAD_BEEF);

    mem_write(32'h0, 32'h7);
    write_en = 1'b1;
    write_data = 32'h1;
    mem_read("mem_same_before", 32'h0, 32'h7);
    tick();
    write_en = 1'b0;
    mem_read("mem_same_after", 32'h0, 32'h1);

    // Reset leaves memory and combinational paths alone
    rst = 1'b1;
    mem_write(32'h20, 32'hAAAA_5555);
    mem_read("mem_wr_in_rst", 32'h20, 32'hAAAA_5555);
    mem_read("mem_kept_in_rst", 32'h10, 32'hDEAD_BEEF);
    alu_chk("alu_in_rst", 5'd1, 32'd3, 32'd4, 32'd7);
    rst = 1'b0;

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
